// File: rtl/cpu_mem_responder_if.sv
// CPU request/response and peripheral port bundle for cpu_mem_responder.
// The slave view belongs to the responder; the master view drives the CPU and peripheral side.
interface cpu_mem_responder_if;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          cpu_request;
  logic [DW-1:0] cpu_address;
  logic          cpu_write;
  logic [SW-1:0] cpu_wstrb;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;

  logic          io_request;
  logic          io_write;
  logic [DW-1:0] io_address;
  logic [DW-1:0] io_wdata;
  logic [SW-1:0] io_wstrb;
  logic [DW-1:0] io_rdata;
  logic          io_ack;

  logic          bus_error;
  logic [DW-1:0] err_address;

  modport slave (
    input  cpu_request, cpu_address, cpu_write, cpu_wstrb, cpu_wdata, io_rdata, io_ack,
    output cpu_rdata, cpu_ack, io_request, io_write, io_address, io_wdata, io_wstrb,
           bus_error, err_address
  );

  modport master (
    output cpu_request, cpu_address, cpu_write, cpu_wstrb, cpu_wdata, io_rdata, io_ack,
    input  cpu_rdata, cpu_ack, io_request, io_write, io_address, io_wdata, io_wstrb,
           bus_error, err_address
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// CPU memory responder: single-cycle on-chip RAM, a handshaked IO window at 0xE000_xxxx
// with a bounded wait, and an error response for every other address.
module cpu_mem_responder #(
  parameter int unsigned RAM_ADDR_BITS = 16,
  parameter int unsigned IO_TIMEOUT    = 255
) (
  input  logic               clock,
  input  logic               reset,
  cpu_mem_responder_if.slave bus
);
  localparam int unsigned WORD_BITS = RAM_ADDR_BITS - 2;
  localparam int unsigned WORDS     = 1 << WORD_BITS;
  localparam int unsigned CNT_W     = (IO_TIMEOUT < 2) ? 1 : $clog2(IO_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IO_WAIT = 2'd1,
    IO_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } io_req_t;

  state_e             state_q;
  logic               cpu_ack_q;
  logic [31:0]        cpu_rdata_q;
  logic               io_request_q;
  io_req_t            io_q;
  logic               bus_error_q;
  logic [31:0]        err_address_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [31:0]        mem [WORDS];

  logic               accept_c;
  logic               is_ram_c;
  logic               is_io_c;
  logic               timeout_c;
  logic [WORD_BITS-1:0] widx_c;

  // A request landing in an ack cycle is taken, so the CPU can issue back-to-back.
  assign accept_c  = bus.cpu_request && ((state_q == IDLE) || cpu_ack_q);
  assign is_ram_c  = (bus.cpu_address >> RAM_ADDR_BITS) == 32'd0;
  assign is_io_c   = bus.cpu_address[31:16] == 16'hE000;
  assign widx_c    = bus.cpu_address[RAM_ADDR_BITS-1:2];
  assign timeout_c = cnt_q == CNT_W'(IO_TIMEOUT - 1);

  // RAM lane writes; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (reset && accept_c && is_ram_c && bus.cpu_write) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.cpu_wstrb[n]) mem[widx_c][8*n +: 8] <= bus.cpu_wdata[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cpu_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      io_request_q  <= 1'b0;
      io_q          <= '0;
      bus_error_q   <= 1'b0;
      err_address_q <= '0;
      cnt_q         <= '0;
    end else begin
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      bus_error_q <= 1'b0;

      unique case (state_q)
        IO_WAIT: begin
          if (bus.io_ack) begin
            io_request_q <= 1'b0;
            cpu_ack_q    <= 1'b1;
            cpu_rdata_q  <= bus.io_rdata;
            state_q      <= IO_DONE;
          end else if (timeout_c) begin
            io_request_q  <= 1'b0;
            cpu_ack_q     <= 1'b1;
            bus_error_q   <= 1'b1;
            err_address_q <= io_q.addr;
            state_q       <= IO_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        IO_DONE: state_q <= IDLE;
        default: ;
      endcase

      // cpu_ack_q is never high in IO_WAIT, so a new request cannot clash with the case above.
      if (accept_c) begin
        if (is_ram_c) begin
          cpu_ack_q <= 1'b1;
          state_q   <= IDLE;
          if (!bus.cpu_write) cpu_rdata_q <= mem[widx_c];
        end else if (is_io_c) begin
          io_request_q <= 1'b1;
          cnt_q        <= '0;
          io_q         <= '{addr:  bus.cpu_address,
                            write: bus.cpu_write,
                            wstrb: bus.cpu_write ? bus.cpu_wstrb : 4'd0,
                            wdata: bus.cpu_write ? bus.cpu_wdata : 32'd0};
          state_q      <= IO_WAIT;
        end else begin
          cpu_ack_q     <= 1'b1;
          bus_error_q   <= 1'b1;
          err_address_q <= bus.cpu_address;
          state_q       <= IDLE;
        end
      end
    end
  end

  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.io_request  = io_request_q;
  assign bus.io_write    = io_q.write;
  assign bus.io_address  = io_q.addr;
  assign bus.io_wstrb    = io_q.wstrb;
  assign bus.io_wdata    = io_q.wdata;
  assign bus.bus_error   = bus_error_q;
  assign bus.err_address = err_address_q;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios plus a randomized RAM/unmapped
// mix scored against a word-array memory model.
module tb_cpu_mem_responder;
  localparam int unsigned IO_TO = 16;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] ref_err;

  cpu_mem_responder_if bus_if();

  cpu_mem_responder #(.RAM_ADDR_BITS(16), .IO_TIMEOUT(IO_TO)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic req, input logic [31:0] a, input logic we,
                       input logic [3:0] s, input logic [31:0] d);
    bus_if.cpu_request = req;
    bus_if.cpu_address = a;
    bus_if.cpu_write   = we;
    bus_if.cpu_wstrb   = s;
    bus_if.cpu_wdata   = d;
  endtask

  // No request, with garbage on the other CPU inputs.
  task automatic idle();
    drive(1'b0, $urandom, 1'($urandom), 4'($urandom), $urandom);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] s,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < 4; n++) if (s[n]) r[8*n +: 8] = d[8*n +: 8];
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus_if.io_ack   = 1'b0;
    bus_if.io_rdata = '0;
    repeat (3) begin
      drive(1'b1, 32'h0000_0100, 1'b0, 4'hF, $urandom);
      step();
    end
    tests++; if (bus_if.cpu_ack !== 1'b0) begin fails++; $display("FAIL rst_ack got=%b exp=0", bus_if.cpu_ack); end
    tests++; if (bus_if.cpu_rdata !== 32'd0) begin fails++; $display("FAIL rst_rdata got=%h exp=0", bus_if.cpu_rdata); end
    tests++; if (bus_if.io_request !== 1'b0) begin fails++; $display("FAIL rst_io_req got=%b exp=0", bus_if.io_request); end
    tests++; if (bus_if.io_write !== 1'b0) begin fails++; $display("FAIL rst_io_write got=%b exp=0", bus_if.io_write); end
    tests++; if (bus_if.io_wstrb !== 4'd0) begin fails++; $display("FAIL rst_io_wstrb got=%h exp=0", bus_if.io_wstrb); end
    tests++; if (bus_if.io_address !== 32'd0) begin fails++; $display("FAIL rst_io_addr got=%h exp=0", bus_if.io_address); end
    tests++; if (bus_if.io_wdata !== 32'd0) begin fails++; $display("FAIL rst_io_wdata got=%h exp=0", bus_if.io_wdata); end
    tests++; if (bus_if.bus_error !== 1'b0) begin fails++; $display("FAIL rst_bus_error got=%b exp=0", bus_if.bus_error); end
    tests++; if (bus_if.err_address !== 32'd0) begin fails++; $display("FAIL rst_err_addr got=%h exp=0", bus_if.err_address); end
    idle();
    reset   = 1'b1;
    ref_err = 32'd0;
  endtask

  task automatic test_ram_basic();
    // First request right after reset release
    drive(1'b1, 32'h0000_0100, 1'b1, 4'b1111, 32'h1234_5678);
    step();
    ref_mem[32'h40] = 32'h1234_5678;
    tests++; if (bus_if.cpu_ack !== 1'b1) begin fails++; $display("FAIL wr_ack got=%b exp=1", bus_if.cpu_ack); end
    tests++; if (bus_if.cpu_rdata !== 32'd0) begin fails++; $display("FAIL wr_rdata got=%h exp=0", bus_if.cpu_rdata); end
    idle();
    step();
    drive(1'b1, 32'h0000_0100, 1'b0, 4'($urandom), $urandom);
    step();
    tests++; if (bus_if.cpu_ack !== 1'b1) begin fails++; $display("FAIL rd_ack got=%b exp=1", bus_if.cpu_ack); end
    tests++; if (bus_if.cpu_rdata !== 32'h1234_5678) begin fails++; $display("FAIL rd_data got=%h exp=12345678", bus_if.cpu_rdata); end
    drive(1'b1, 32'h0000_0102, 1'b1, 4'b0100, 32'h00AB_0000);
    step();
    ref_mem[32'h40] = merge(ref_mem[32'h40], 4'b0100, 32'h00AB_0000);
    tests++; if (bus_if.cpu_ack !== 1'b1) begin fails++; $display("FAIL lane_wr_ack got=%b exp=1", bus_if.cpu_ack); end
    // Read issued in the write's ack cycle
    drive(1'b1, 32'h0000_0100, 1'b0, 4'hF, $urandom);
    step();
    tests++; if (bus_if.cpu_ack !== 1'b1) begin fails++; $display("FAIL b2b_ack got=%b exp=1", bus_if.cpu_ack); end
    tests++; if (bus_if.cpu_rdata !== 32'h12AB_5678) begin fails++; $display("FAIL b2b_data got=%h exp=12ab5678", bus_if.cpu_rdata); end
    drive(1'b1, 32'h0000_0103, 1'b0, 4'h0, $urandom);
    step();
    tests++; if (bus_if.cpu_rdata !== 32'h12AB_5678) begin fails++; $display("FAIL unaligned_rd got=%h exp=12ab5678", bus_if.cpu_rdata); end
    idle();
    step();
    tests++; if (bus_if.cpu_ack !== 1'b0 || bus_if.cpu_rdata !== 32'd0) begin
      fails++; $display("FAIL idle_quiet got ack=%b rdata=%h exp ack=0 rdata=0", bus_if.cpu_ack, bus_if.cpu_rdata); end
  endtask

  task automatic test_io_read();
    logic [31:0] d;
    drive(1'b1, 32'hE000_0010, 1'b0, 4'($urandom), $urandom);
    step();
    tests++; if (bus_if.io_request !== 1'b1 || bus_if.io_address !== 32'hE000_0010 || bus_if.io_write !== 1'b0) begin
      fails++; $display("FAIL io_issue got req=%b addr=%h wr=%b exp req=1 addr=e0000010 wr=0",
                        bus_if.io_request, bus_if.io_address, bus_if.io_write); end
    tests++; if (bus_if.cpu_ack !== 1'b0) begin fails++; $display("FAIL io_early_ack got=%b exp=0", bus_if.cpu_ack); end
    // A RAM write attempted during IO_WAIT must be dropped
    repeat (3) begin
      drive(1'b1, 32'h0000_0100, 1'b1, 4'hF, 32'hDEAD_BEEF);
      step();
      tests++; if (bus_if.io_request !== 1'b1 || bus_if.cpu_ack !== 1'b0) begin
        fails++; $display("FAIL io_hold got req=%b ack=%b exp req=1 ack=0", bus_if.io_request, bus_if.cpu_ack); end
    end
    idle();
    bus_if.io_ack   = 1'b1;
    bus_if.io_rdata = 32'hCAFE_F00D;
    step();
    bus_if.io_ack = 1'b0;
    tests++; if (bus_if.cpu_ack !== 1'b1 || bus_if.cpu_rdata !== 32'hCAFE_F00D || bus_if.bus_error !== 1'b0) begin
      fails++; $display("FAIL io_done got ack=%b rdata=%h err=%b exp ack=1 rdata=cafef00d err=0",
                        bus_if.cpu_ack, bus_if.cpu_rdata, bus_if.bus_error); end
    tests++; if (bus_if.io_request !== 1'b0) begin fails++; $display("FAIL io_drop got=%b exp=0", bus_if.io_request); end
    step();
    tests++; if (bus_if.cpu_ack !== 1'b0) begin fails++; $display("FAIL io_single_ack got=%b exp=0", bus_if.cpu_ack); end
    // Stray io_ack while idle
    bus_if.io_ack   = 1'b1;
    bus_if.io_rdata = $urandom;
    step();
    bus_if.io_ack = 1'b0;
    tests++; if (bus_if.cpu_ack !== 1'b0) begin fails++; $display("FAIL stray_io_ack got=%b exp=0", bus_if.cpu_ack); end
    drive(1'b1, 32'h0000_0100, 1'b0, 4'hF, $urandom);
    step();
    d = ref_mem[32'h40];
    tests++; if (bus_if.cpu_rdata !== d) begin fails++; $display("FAIL ignored_wr got=%h exp=%h", bus_if.cpu_rdata, d); end
    idle();
  endtask

  task automatic test_io_write();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, d, r;
      logic [3:0]  s;
      int          dly;
      a = {16'hE000, 16'($urandom)};
      d = $urandom;
      r = $urandom;
      s = 4'($urandom);
      dly = $urandom_range(0, 5);
      drive(1'b1, a, 1'b1, s, d);
      step();
      idle();
      tests++; if (bus_if.io_request !== 1'b1 || bus_if.io_address !== a || bus_if.io_write !== 1'b1 ||
                   bus_if.io_wstrb !== s || bus_if.io_wdata !== d) begin
        fails++; $display("FAIL iow_issue got req=%b addr=%h wr=%b strb=%h data=%h exp req=1 addr=%h wr=1 strb=%h data=%h",
                          bus_if.io_request, bus_if.io_address, bus_if.io_write, bus_if.io_wstrb, bus_if.io_wdata, a, s, d); end
      repeat (dly) begin
        step();
        tests++; if (bus_if.io_request !== 1'b1 || bus_if.io_wdata !== d || bus_if.cpu_ack !== 1'b0) begin
          fails++; $display("FAIL iow_hold got req=%b data=%h ack=%b exp req=1 data=%h ack=0",
                            bus_if.io_request, bus_if.io_wdata, bus_if.cpu_ack, d); end
      end
      bus_if.io_ack   = 1'b1;
      bus_if.io_rdata = r;
      step();
      bus_if.io_ack = 1'b0;
      tests++; if (bus_if.cpu_ack !== 1'b1 || bus_if.cpu_rdata !== r) begin
        fails++; $display("FAIL iow_done got ack=%b rdata=%h exp ack=1 rdata=%h", bus_if.cpu_ack, bus_if.cpu_rdata, r); end
      step();
    end
  endtask

  task automatic test_timeout();
    int hi;
    drive(1'b1, 32'hE000_0020, 1'b0, 4'hF, $urandom);
    step();
    idle();
    hi = 0;
    while (bus_if.io_request === 1'b1 && hi < 100) begin
      tests++; if (bus_if.cpu_ack !== 1'b0) begin fails++; $display("FAIL to_early_ack got=%b exp=0", bus_if.cpu_ack); end
      hi++;
      step();
    end
    tests++; if (hi != IO_TO) begin fails++; $display("FAIL to_cycles got=%0d exp=%0d", hi, IO_TO); end
    tests++; if (bus_if.cpu_ack !== 1'b1 || bus_if.bus_error !== 1'b1 || bus_if.cpu_rdata !== 32'd0) begin
      fails++; $display("FAIL to_resp got ack=%b err=%b rdata=%h exp ack=1 err=1 rdata=0",
                        bus_if.cpu_ack, bus_if.bus_error, bus_if.cpu_rdata); end
    ref_err = 32'hE000_0020;
    tests++; if (bus_if.err_address !== ref_err) begin fails++; $display("FAIL to_err_addr got=%h exp=%h", bus_if.err_address, ref_err); end
    step();
    tests++; if (bus_if.cpu_ack !== 1'b0 || bus_if.bus_error !== 1'b0) begin
      fails++; $display("FAIL to_pulse got ack=%b err=%b exp 0 0", bus_if.cpu_ack, bus_if.bus_error); end
  endtask

  // io_ack arriving in the last permitted wait cycle beats the timeout
  task automatic test_ack_race();
    logic [31:0] r;
    r = $urandom;
    drive(1'b1, 32'hE000_0030, 1'b0, 4'hF, $urandom);
    step();
    idle();
    repeat (IO_TO - 1) step();
    tests++; if (bus_if.io_request !== 1'b1) begin fails++; $display("FAIL race_req got=%b exp=1", bus_if.io_request); end
    bus_if.io_ack   = 1'b1;
    bus_if.io_rdata = r;
    step();
    bus_if.io_ack = 1'b0;
    tests++; if (bus_if.cpu_ack !== 1'b1 || bus_if.bus_error !== 1'b0 || bus_if.cpu_rdata !== r) begin
      fails++; $display("FAIL race_resp got ack=%b err=%b rdata=%h exp ack=1 err=0 rdata=%h",
                        bus_if.cpu_ack, bus_if.bus_error, bus_if.cpu_rdata, r); end
    tests++; if (bus_if.err_address !== ref_err) begin fails++; $display("FAIL race_err_addr got=%h exp=%h", bus_if.err_address, ref_err); end
    step();
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    drive(1'b1, 32'h4000_0000, 1'b0, 4'hF, $urandom);
    step();
    ref_err = 32'h4000_0000;
    tests++; if (bus_if.cpu_ack !== 1'b1 || bus_if.bus_error !== 1'b1 || bus_if.cpu_rdata !== 32'd0) begin
      fails++; $display("FAIL unm_resp got ack=%b err=%b rdata=%h exp ack=1 err=1 rdata=0",
                        bus_if.cpu_ack, bus_if.bus_error, bus_if.cpu_rdata); end
    tests++; if (bus_if.err_address !== ref_err) begin fails++; $display("FAIL unm_err_addr got=%h exp=%h", bus_if.err_address, ref_err); end
    drive(1'b1, 32'h4000_0100, 1'b1, 4'hF, 32'h5555_AAAA);
    step();
    ref_err = 32'h4000_0100;
    drive(1'b1, 32'h0000_0100, 1'b0, 4'hF, $urandom);
    step();
    d = ref_mem[32'h40];
    tests++; if (bus_if.cpu_rdata !== d || bus_if.bus_error !== 1'b0) begin
      fails++; $display("FAIL unm_wr_dropped got rdata=%h err=%b exp rdata=%h err=0", bus_if.cpu_rdata, bus_if.bus_error, d); end
    tests++; if (bus_if.err_address !== ref_err) begin fails++; $display("FAIL unm_err_hold got=%h exp=%h", bus_if.err_address, ref_err); end
    idle();
    step();
  endtask

  task automatic test_random();
    for (int w = 0; w < 64; w++) begin
      logic [31:0] d;
      d = $urandom;
      drive(1'b1, 32'(w * 4), 1'b1, 4'hF, d);
      ref_mem[32'(w)] = d;
      step();
    end
    for (int i = 0; i < 300; i++) begin
      int          kind;
      logic [31:0] a, d, e_rdata;
      logic [3:0]  s;
      logic        we, e_ack, e_err;
      int unsigned idx;
      kind = $urandom_range(0, 9);
      d = $urandom;
      s = 4'($urandom);
      we = 1'($urandom);
      e_ack = 1'b1; e_err = 1'b0; e_rdata = 32'd0;
      if (kind < 2) begin
        idle();
        e_ack = 1'b0;
      end else if (kind < 8) begin
        idx = $urandom_range(0, 63);
        a = 32'(idx * 4) | 32'($urandom_range(0, 3));
        drive(1'b1, a, we, s, d);
        if (we) ref_mem[idx] = merge(ref_mem[idx], s, d);
        else    e_rdata = ref_mem[idx];
      end else begin
        a = $urandom;
        if (a[31:16] == 16'h0000 || a[31:16] == 16'hE000) a[31:16] = 16'h4000;
        drive(1'b1, a, we, s, d);
        e_err = 1'b1;
        ref_err = a;
      end
      step();
      tests++; if (bus_if.cpu_ack !== e_ack || bus_if.cpu_rdata !== e_rdata || bus_if.bus_error !== e_err ||
                   bus_if.err_address !== ref_err) begin
        fails++; $display("FAIL rand[%0d] got ack=%b rdata=%h err=%b eaddr=%h exp ack=%b rdata=%h err=%b eaddr=%h", i,
                          bus_if.cpu_ack, bus_if.cpu_rdata, bus_if.bus_error, bus_if.err_address,
                          e_ack, e_rdata, e_err, ref_err); end
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid_io();
    logic [31:0] d;
    drive(1'b1, 32'hE000_0040, 1'b0, 4'hF, $urandom);
    step();
    idle();
    step();
    #2 reset = 1'b0;
    #1;
    ref_err = 32'd0;
    tests++; if (bus_if.io_request !== 1'b0 || bus_if.cpu_ack !== 1'b0 || bus_if.err_address !== 32'd0) begin
      fails++; $display("FAIL mid_rst got req=%b ack=%b eaddr=%h exp 0 0 0", bus_if.io_request, bus_if.cpu_ack, bus_if.err_address); end
    bus_if.io_ack = 1'b1;
    step();
    step();
    bus_if.io_ack = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      step();
      tests++; if (bus_if.cpu_ack !== 1'b0 || bus_if.io_request !== 1'b0) begin
        fails++; $display("FAIL post_rst_quiet got ack=%b req=%b exp 0 0", bus_if.cpu_ack, bus_if.io_request); end
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    drive(1'b1, 32'h0000_0010, 1'b0, 4'hF, $urandom);
    step();
    d = ref_mem[32'h4];
    tests++; if (bus_if.cpu_ack !== 1'b1 || bus_if.cpu_rdata !== d) begin
      fails++; $display("FAIL ram_retained got ack=%b rdata=%h exp ack=1 rdata=%h", bus_if.cpu_ack, bus_if.cpu_rdata, d); end
    idle();
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_ram_basic();
    test_io_read();
    test_io_write();
    test_timeout();
    test_ack_race();
    test_unmapped();
    test_random();
    test_reset_mid_io();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 The block SHALL have parameter RAM_ADDR_BITS, default 16, which sets the on-chip RAM size to 2^RAM_ADDR_BITS bytes.
REQ-002 The block SHALL have parameter IO_TIMEOUT, default 255, which sets the maximum cycles io_request may wait for io_ack.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 cpu_request  input  1  one-cycle request strobe from the CPU.
REQ-006 cpu_address  input  32  byte address.
REQ-007 cpu_write  input  1  1 = write, 0 = read.
REQ-008 cpu_wstrb  input  4  byte-lane write enables; lane n is bits [8n+7:8n].
REQ-009 cpu_wdata  input  32  write data, valid only on enabled lanes.
REQ-010 cpu_rdata  output  32  read data, valid while cpu_ack=1.
REQ-011 cpu_ack  output  1  one-cycle completion pulse.
REQ-012 io_request, io_write  output  1 each; io_address, io_wdata  output  32 each; io_wstrb  output  4  peripheral port.
REQ-013 io_rdata  input  32; io_ack  input  1  peripheral completion.
REQ-014 bus_error  output  1  one-cycle pulse on an unmapped access or timeout; err_address  output  32  address of the last errored access.

Function
REQ-015 Address decode SHALL be: RAM when cpu_address[31:RAM_ADDR_BITS]==0; IO when cpu_address[31:16]==16'hE000; all other addresses are unmapped.
REQ-016 The FSM SHALL have three states: IDLE, IO_WAIT and IO_DONE.
REQ-017 The block SHALL accept a request when cpu_request=1 and either state==IDLE or cpu_ack=1 in the same cycle, so a request issued in an ack cycle is accepted.
REQ-018 When cpu_request=0, cpu_address, cpu_write, cpu_wstrb and cpu_wdata SHALL be ignored; when cpu_write=0, cpu_wstrb and cpu_wdata SHALL be ignored.
REQ-019 A cpu_request arriving outside the acceptance condition SHALL be ignored, with no state change.
REQ-020 RAM read: request in cycle N SHALL give cpu_ack=1 in cycle N+1, with cpu_rdata = the word at cpu_address[RAM_ADDR_BITS-1:2].
REQ-021 RAM write: in cycle N the block SHALL update only the lanes enabled by cpu_wstrb, then assert cpu_ack=1 in cycle N+1 with cpu_rdata=0.
REQ-022 Address bits [1:0] SHALL be ignored for RAM; reads always return the whole word.
REQ-023 A read of a word written in the immediately preceding accepted request SHALL return the new data.
REQ-024 IO access: in cycle N+1 the block SHALL register io_address, io_write, io_wstrb and io_wdata, assert io_request, and enter IO_WAIT.
REQ-025 In IO_WAIT, io_request and the io outputs SHALL be held until io_ack=1.
REQ-026 On io_ack=1 the block SHALL capture io_rdata and enter IO_DONE; in IO_DONE it SHALL drive cpu_ack=1 with the captured data for one cycle, then return to IDLE.
REQ-027 IO timeout: an internal counter SHALL clear on IO_WAIT entry and increment each IO_WAIT cycle.
REQ-028 When the timeout counter reaches IO_TIMEOUT with no io_ack, the block SHALL drop io_request, enter IO_DONE with cpu_rdata=0, pulse bus_error, and latch err_address.
REQ-029 If io_ack and the timeout occur in the same cycle, io_ack SHALL win and no error is raised.
REQ-030 io_ack while not in IO_WAIT SHALL be ignored.
REQ-031 Unmapped access: request in cycle N SHALL give cpu_ack=1 and bus_error=1 in cycle N+1, with cpu_rdata=0 and err_address=cpu_address; writes are dropped.
REQ-032 Exactly one cpu_ack pulse SHALL be produced per accepted request, and cpu_ack SHALL never be asserted without a request.
REQ-033 When cpu_ack=0, cpu_rdata SHALL be 0.

Reset
REQ-034 While reset=0: state=IDLE, cpu_ack=0, cpu_rdata=0, io_request=0, io_write=0, io_wstrb=0, io_address=0, io_wdata=0, bus_error=0, err_address=0, timeout counter=0.
REQ-035 Reset asserted mid-IO-transaction SHALL abandon the transaction immediately with no cpu_ack; RAM contents are not cleared.
REQ-036 The first request SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-037 Write 0x12345678, wstrb 4'b1111, to 0x100, then read 0x100 -> both acks one cycle after each request; read rdata=0x12345678.
REQ-038 Write wstrb 4'b0100, wdata 0x00AB0000 to 0x102, then read 0x100 -> rdata=0x12AB5678.
REQ-039 Read 0x100 in the ack cycle of the preceding write, back-to-back -> accepted; ack on the next cycle with the updated data.
REQ-040 Read 0xE0000010 with io_ack after 3 IO_WAIT cycles, io_rdata=0xCAFEF00D -> cpu_ack one cycle after io_ack, rdata=0xCAFEF00D.
REQ-041 With IO_TIMEOUT=16, read 0xE0000020 with no io_ack -> io_request drops after 16 cycles; cpu_ack and bus_error pulse together; rdata=0; err_address=0xE0000020.
REQ-042 Read 0x40000000 -> ack next cycle with bus_error=1 and rdata=0; assert reset during IO_WAIT -> io_request=0 and no cpu_ack.
